// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts N-1 down to 0 and ticks on the last cycle of every period.
module uart_bit_timer #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] n,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_reload;
    logic                 r_run;
    logic [DIV_WIDTH-1:0] w_load_val;

    // A divisor of 0 behaves as 1, so the reload value saturates at 0
    assign w_load_val = (n == '0) ? '0 : n - DIV_WIDTH'(1);
    assign tick       = r_run && (r_cnt == '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt    <= '0;
            r_reload <= '0;
            r_run    <= 1'b0;
        end else if (load) begin
            r_cnt    <= w_load_val;
            r_reload <= w_load_val;
            r_run    <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_cnt <= r_reload;
            end else begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them onto txd.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_data,
    output logic                 fifo_ren,
    output logic                 txd,
    output logic                 busy
);

    localparam int unsigned              IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_tx_state_t              r_state;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [IDX_W-1:0]            r_bit_idx;
    logic                        r_stop_cnt;
    logic                        r_par;
    logic                        r_par_en;
    logic                        r_two_stop;
    logic                        r_txd;
    logic                        r_busy;
    logic                        w_pop;
    logic                        w_tick;

    // Pop is gated by reset so a byte is never consumed during a reset cycle
    assign w_pop    = (r_state == IDLE) && tx_en && !fifo_empty && !areset;
    assign fifo_ren = w_pop;
    assign txd      = r_txd;
    assign busy     = r_busy;

    uart_bit_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_bit_timer (
        .aclk   (aclk),
        .areset (areset),
        .load   (w_pop),
        .n      (divisor),
        .tick   (w_tick)
    );

    // r_par starts at parity_odd and accumulates each data bit as it is driven out
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift    <= fifo_data;
                        r_par      <= parity_odd;
                        r_par_en   <= parity_en;
                        r_two_stop <= two_stop;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_txd   <= r_shift[0];
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_bit_idx <= '0;
                            if (r_par_en) begin
                                r_txd   <= r_par;
                                r_state <= PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_txd     <= r_shift[0];
                            r_par     <= r_par ^ r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_two_stop && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level line model plus directed literal checks.
module tb_uart_tx;

    localparam int unsigned DW   = 16;
    localparam int          HMAX = 4096;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] divisor;
    logic          parity_en;
    logic          parity_odd;
    logic          two_stop;
    logic          tx_en;
    logic          fifo_empty;
    logic [7:0]    fifo_data;
    logic          fifo_ren;
    logic          txd;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic t;
        logic b;
    } samp_t;

    logic [7:0] fq[$];
    samp_t      mq[$];
    logic       hist_txd[HMAX];
    logic       hist_busy[HMAX];
    int         cyc = 0;
    int         ren_times[$];
    int         busy_runs[$];
    int         busy_run = 0;
    int         rst_t = -1;

    always #5 aclk = ~aclk;

    uart_tx #(
        .DIV_WIDTH (DW)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .divisor    (divisor),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_ren   (fifo_ren),
        .txd        (txd),
        .busy       (busy)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    // Expected line for one frame: start, 8 data LSB-first, optional parity, stop bit(s)
    task automatic push_frame(input logic [7:0] d, input int n, input logic pe,
                              input logic po, input logic ts);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < n; c++) mq.push_back('{t: bits[k], b: 1'b1});
        end
    endtask

    function automatic logic get_txd(input int t);
        return (t >= 0 && t < HMAX) ? hist_txd[t] : 1'bx;
    endfunction

    function automatic logic get_busy(input int t);
        return (t >= 0 && t < HMAX) ? hist_busy[t] : 1'bx;
    endfunction

    function automatic int ren_at(input int idx);
        return (idx < ren_times.size()) ? ren_times[idx] : -1000;
    endfunction

    function automatic int run_at(input int idx);
        return (idx < busy_runs.size()) ? busy_runs[idx] : -1;
    endfunction

    function automatic logic [7:0] decode(input int t0, input int n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = get_txd(t0 + 1 + n * (1 + i));
        return r;
    endfunction

    // Monitor and per-cycle comparison against the model, then model/FIFO advance
    always begin
        logic       e_t, e_b, e_r, s_rst, s_ren, s_pe, s_po, s_ts;
        logic [7:0] s_d;
        int         s_n;
        @(negedge aclk);
        if (mon_en) begin
            cyc++;
            if (cyc < HMAX) begin
                hist_txd[cyc]  = txd;
                hist_busy[cyc] = busy;
            end
            if (fifo_ren) ren_times.push_back(cyc);
            if (areset) rst_t = cyc;
            if (busy) busy_run++;
            else if (busy_run > 0) begin
                busy_runs.push_back(busy_run);
                busy_run = 0;
            end
            e_t = (mq.size() == 0) ? 1'b1 : mq[0].t;
            e_b = (mq.size() == 0) ? 1'b0 : mq[0].b;
            e_r = (mq.size() == 0) && tx_en && !fifo_empty && !areset;
            chk("txd", txd, e_t);
            chk("busy", busy, e_b);
            chk("fifo_ren", fifo_ren, e_r);
            s_rst = areset;
            s_ren = fifo_ren;
            s_d   = fifo_data;
            s_n   = (divisor == '0) ? 1 : int'(divisor);
            s_pe  = parity_en;
            s_po  = parity_odd;
            s_ts  = two_stop;
            @(posedge aclk);
            #1;
            if (s_rst) mq.delete();
            else begin
                if (mq.size() > 0) void'(mq.pop_front());
                if (e_r) push_frame(s_d, s_n, s_pe, s_po, s_ts);
            end
            if (s_ren && fq.size() > 0) void'(fq.pop_front());
            refresh_fifo();
        end
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        refresh_fifo();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(fq.size() == 0 && busy == 1'b0 && fifo_ren == 1'b0) && k < budget);
        chk("drain_done", int'(k < budget), 1);
        repeat (2) step();
    endtask

    task automatic wait_ren(output int t, input int budget);
        int n0 = ren_times.size();
        int k  = 0;
        while (ren_times.size() == n0 && k < budget) begin
            step();
            k++;
        end
        chk("wait_ren_done", int'(ren_times.size() > n0), 1);
        t = ren_at(n0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0, nb, t0, t1, cs, zeros, k;
        int exp_bits[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

        areset     = 1'b1;
        tx_en      = 1'b0;
        divisor    = 16'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        refresh_fifo();
        step();
        mon_en = 1'b1;
        @(negedge aclk);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ren", fifo_ren, 0);
        step();
        areset = 1'b0;

        // Basic frame: 0x55, N=3, no parity, one stop
        step();
        n0 = ren_times.size();
        nb = busy_runs.size();
        tx_en = 1'b1;
        push(8'h55);
        drain(200);
        t0 = ren_at(n0);
        chk("t1_ren_count", ren_times.size() - n0, 1);
        chk("t1_busy_len", run_at(nb), 30);
        chk("t1_busy_rise", get_busy(t0 + 1), 1);
        for (int j = 0; j < 10; j++)
            for (int c = 0; c < 3; c++)
                chk("t1_line_bit", get_txd(t0 + 1 + 3 * j + c), exp_bits[j]);

        // Even parity, two stop bits: 0x07 -> parity 1
        divisor    = 16'd2;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        two_stop   = 1'b1;
        n0 = ren_times.size();
        nb = busy_runs.size();
        push(8'h07);
        drain(200);
        t0 = ren_at(n0);
        chk("t2_busy_len", run_at(nb), 24);
        chk("t2_parity_even", get_txd(t0 + 19), 1);
        chk("t2_parity_even_b", get_txd(t0 + 20), 1);
        for (int c = 21; c <= 24; c++) chk("t2_stop", get_txd(c + t0), 1);
        chk("t2_byte", decode(t0, 2), 8'h07);

        // Odd parity on the same byte -> parity 0
        parity_odd = 1'b1;
        n0 = ren_times.size();
        nb = busy_runs.size();
        push(8'h07);
        drain(200);
        t0 = ren_at(n0);
        chk("t2o_busy_len", run_at(nb), 24);
        chk("t2o_parity_odd", get_txd(t0 + 19), 0);

        // Back-to-back frames at N=1
        divisor    = 16'd1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        n0 = ren_times.size();
        nb = busy_runs.size();
        push(8'hA5);
        push(8'h3C);
        drain(200);
        t0 = ren_at(n0);
        t1 = ren_at(n0 + 1);
        chk("t3_ren_gap", t1 - t0, 11);
        chk("t3_stop_high", get_txd(t0 + 10), 1);
        chk("t3_idle_high", get_txd(t0 + 11), 1);
        chk("t3_idle_busy", get_busy(t0 + 11), 0);
        chk("t3_second_start", get_txd(t0 + 12), 0);
        chk("t3_byte0", decode(t0, 1), 8'hA5);
        chk("t3_byte1", decode(t1, 1), 8'h3C);
        chk("t3_busy0", run_at(nb), 10);
        chk("t3_busy1", run_at(nb + 1), 10);

        // Divisor 0 behaves as 1
        divisor = 16'd0;
        n0 = ren_times.size();
        nb = busy_runs.size();
        push(8'hFF);
        drain(200);
        chk("t4_busy_len", run_at(nb), 10);
        chk("t4_byte", decode(ren_at(n0), 1), 8'hFF);

        // tx_en low holds off a non-empty FIFO
        tx_en = 1'b0;
        n0 = ren_times.size();
        push(8'h12);
        cs = cyc + 1;
        repeat (51) step();
        zeros = 0;
        for (int c = 0; c < 50; c++) if (get_txd(cs + c) !== 1'b1) zeros++;
        chk("t4_idle_line", zeros, 0);
        chk("t4_no_ren", ren_times.size() - n0, 0);
        tx_en = 1'b1;
        drain(200);
        chk("t4_late_byte", decode(ren_at(n0), 1), 8'h12);

        // Reset during data bit 4 at N=4; the next byte goes out whole
        divisor = 16'd4;
        n0 = ren_times.size();
        nb = busy_runs.size();
        push(8'h96);
        push(8'h3B);
        wait_ren(t0, 20);
        k = 0;
        while (cyc < t0 + 22 && k < 100) begin
            step();
            k++;
        end
        areset = 1'b1;
        step();
        areset = 1'b0;
        drain(400);
        chk("t5_rst_cycle", rst_t, t0 + 23);
        chk("t5_txd_after", get_txd(rst_t + 1), 1);
        chk("t5_busy_after", get_busy(rst_t + 1), 0);
        chk("t5_ren_count", ren_times.size() - n0, 2);
        chk("t5_repop_time", ren_at(n0 + 1), rst_t + 1);
        chk("t5_cut_busy", run_at(nb), 23);
        chk("t5_full_busy", run_at(nb + 1), 40);
        chk("t5_byte", decode(ren_at(n0 + 1), 4), 8'h3B);

        // Divisor change mid-frame takes effect on the next frame only
        divisor = 16'd4;
        n0 = ren_times.size();
        nb = busy_runs.size();
        push(8'hC3);
        wait_ren(t0, 20);
        k = 0;
        while (cyc < t0 + 10 && k < 100) begin
            step();
            k++;
        end
        divisor = 16'd2;
        push(8'h5A);
        drain(400);
        t1 = ren_at(n0 + 1);
        chk("t6_ren_gap", t1 - t0, 41);
        chk("t6_busy0", run_at(nb), 40);
        chk("t6_busy1", run_at(nb + 1), 20);
        chk("t6_byte0", decode(t0, 4), 8'hC3);
        chk("t6_byte1", decode(t1, 2), 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
